// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants: operand width, one-hot handshake states, timing.
package rsa_pkg;

    // Default operand / modulus width and the double-width product size.
    localparam int unsigned BITS       = 64;
    localparam int unsigned DOUBLEBITS = 2 * BITS;

    // Cycles from the capture edge to done for one Montgomery product.
    localparam int unsigned MM_LATENCY = BITS + 1;

    // One-hot state codes, shared with the exponent controller.
    localparam int unsigned ST_W    = 4;
    localparam logic [3:0]  ST_IDLE = 4'b0001;
    localparam logic [3:0]  ST_CALC = 4'b0010;
    localparam logic [3:0]  ST_CORR = 4'b0100;
    localparam logic [3:0]  ST_DONE = 4'b1000;

    typedef enum logic [ST_W-1:0] {
        MM_IDLE = ST_IDLE,
        MM_CALC = ST_CALC,
        MM_CORR = ST_CORR,
        MM_DONE = ST_DONE
    } mm_state_e;

    // Handshake latency for an arbitrary operand width.
    function automatic int unsigned mm_latency(input int unsigned bits);
        return bits + 1;
    endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: T_next = (T + a*B + q*M) / 2.
module mont_step #(
    parameter int unsigned BITS = 64
) (
    input  logic [BITS+1:0] T,
    input  logic            a_bit,
    input  logic [BITS-1:0] B,
    input  logic [BITS-1:0] M,
    output logic [BITS+1:0] T_next
);

    // One spare bit above T so the intermediate sums never truncate,
    // even when the caller breaks the A,B < M contract.
    localparam int unsigned SUM_W = BITS + 3;

    logic [SUM_W-1:0] u;
    logic [SUM_W-1:0] v;

    // Add the partial product, then the modulus if needed to make the sum even.
    always_comb begin
        u      = SUM_W'(T) + (a_bit ? SUM_W'(B) : SUM_W'(0));
        v      = u + (u[0] ? SUM_W'(M) : SUM_W'(0));
        T_next = (BITS+2)'(v >> 1);
    end

endmodule

// File: rtl/mont_mult_responder.sv
// Radix-2 iterative Montgomery multiplier, S = A*B*2^-BITS mod M,
// responding to a level go/done handshake.
module mont_mult_responder #(
    parameter int unsigned BITS  = rsa_pkg::BITS,
    parameter int unsigned CNT_W = $clog2(BITS) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic [BITS-1:0] M,
    output logic            done,
    output logic            err,
    output logic [BITS-1:0] S
);

    import rsa_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BITS - 1);

    mm_state_e        state;
    logic [BITS-1:0]  a_r;
    logic [BITS-1:0]  b_r;
    logic [BITS-1:0]  m_r;
    logic [BITS+1:0]  t;
    logic [CNT_W-1:0] cnt;
    logic             err_pend;

    logic [BITS+1:0]  t_next_c;
    logic             a_bit_c;
    logic [BITS-1:0]  s_corr_c;

    // Multiplier bit consumed by the current iteration.
    always_comb begin
        a_bit_c = a_r[cnt[CNT_W-2:0]];
    end

    mont_step #(
        .BITS (BITS)
    ) u_step (
        .T      (t),
        .a_bit  (a_bit_c),
        .B      (b_r),
        .M      (m_r),
        .T_next (t_next_c)
    );

    // Final conditional subtraction; the result is < M so the low BITS bits suffice.
    always_comb begin
        s_corr_c = t[BITS-1:0];
        if (t >= (BITS+2)'(m_r)) begin
            s_corr_c = t[BITS-1:0] - m_r;
        end
    end

    // Handshake FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= MM_IDLE;
            done     <= 1'b0;
            err      <= 1'b0;
            S        <= '0;
            cnt      <= '0;
            t        <= '0;
            a_r      <= '0;
            b_r      <= '0;
            m_r      <= '0;
            err_pend <= 1'b0;
        end else begin
            case (state)
                MM_IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        a_r <= A;
                        b_r <= B;
                        m_r <= M;
                        t   <= '0;
                        cnt <= '0;
                        err <= 1'b0;
                        // An even modulus has no inverse of 2; skip straight to reporting.
                        if (!M[0]) begin
                            err_pend <= 1'b1;
                            state    <= MM_CORR;
                        end else begin
                            err_pend <= 1'b0;
                            state    <= MM_CALC;
                        end
                    end
                end

                MM_CALC: begin
                    if (!go) begin
                        state <= MM_IDLE;
                    end else begin
                        t   <= t_next_c;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_ITER) begin
                            state <= MM_CORR;
                        end
                    end
                end

                MM_CORR: begin
                    if (!go) begin
                        state <= MM_IDLE;
                    end else begin
                        S     <= s_corr_c;
                        err   <= err_pend;
                        done  <= 1'b1;
                        state <= MM_DONE;
                    end
                end

                MM_DONE: begin
                    // Hold the result until the initiator drops go; S stays put afterwards.
                    if (!go) begin
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= MM_IDLE;
                    end
                end

                default: begin
                    state <= MM_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mult_responder.sv
// Directed + exhaustive-small bench for mont_mult_responder at BITS=8.
module tb_mont_mult_responder;

    localparam int unsigned W   = 8;
    localparam int          LAT = 9;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         go    = 1'b0;
    logic [W-1:0] a_i   = '0;
    logic [W-1:0] b_i   = '0;
    logic [W-1:0] m_i   = '0;
    logic         done;
    logic         err;
    logic [W-1:0] s;

    mont_mult_responder #(
        .BITS (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .A     (a_i),
        .B     (b_i),
        .M     (m_i),
        .done  (done),
        .err   (err),
        .S     (s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    logic done_q = 1'b0;

    // Monitor: every rising done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done && !done_q) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_done actual S=%0d err=%0d required no result", s, err);
            end else begin
                e = exp_q.pop_front();
                if (s !== e.s || err !== e.err) begin
                    errors = errors + 1;
                    $display("FAIL result actual S=%0d err=%0d required S=%0d err=%0d",
                             s, err, e.s, e.err);
                end
            end
        end
        done_q <= done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: A*B*R^-1 mod M with R = 256, R^-1 found by search.
    function automatic int mont_ref(input int a, input int b, input int mm);
        int rinv;
        rinv = 0;
        for (int x = 1; x < mm; x++) begin
            if (((256 * x) % mm) == 1) rinv = x;
        end
        return (a * b * rinv) % mm;
    endfunction

    // One complete handshake: raise go, measure latency, optionally hold, drop go.
    task automatic run_op(input int a, input int b, input int mm,
                          input int exp_s, input logic exp_err,
                          input int exp_lat, input int hold);
        int  cap;
        int  lat;
        bit  seen;
        @(negedge clk);
        a_i = W'(a);
        b_i = W'(b);
        m_i = W'(mm);
        go  = 1'b1;
        exp_q.push_back('{s: W'(exp_s), err: exp_err});
        @(posedge clk);
        #1 cap = cyc;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = cyc - cap;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a_i = a_i ^ 8'hA5;
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_s", 32'(s), 32'(exp_s));
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_done", 32'(done), 32'd0);
        chk("drop_err", 32'(err), 32'd0);
    endtask

    initial begin
        int seen_abort;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_s", 32'(s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed products, M = 13.
        run_op(5, 7, 13, 1, 1'b0, LAT, 0);
        run_op(1, 3, 13, 9, 1'b0, LAT, 0);
        run_op(1, 1, 13, 3, 1'b0, LAT, 0);
        run_op(0, 12, 13, 0, 1'b0, LAT, 0);
        run_op(12, 12, 13, 3, 1'b0, LAT, 0);

        // Even modulus.
        run_op(5, 7, 12, 0, 1'b1, 1, 0);

        // Handshake hold with A changing during DONE.
        run_op(5, 7, 13, 1, 1'b0, LAT, 20);

        // Abort at iteration 4: no done, S keeps the last result (1).
        @(negedge clk);
        a_i = 8'd12; b_i = 8'd12; m_i = 8'd13; go = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        seen_abort = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen_abort = 1;
        end
        chk("abort_no_done", 32'(seen_abort), 32'd0);
        chk("abort_s_kept", 32'(s), 32'd1);
        run_op(5, 7, 13, 1, 1'b0, LAT, 0);

        // Reset pulse mid-CALC.
        @(negedge clk);
        a_i = 8'd12; b_i = 8'd12; m_i = 8'd13; go = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        go    = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(5, 7, 13, 1, 1'b0, LAT, 0);

        // Exhaustive sweep of A,B < 13.
        for (int x = 0; x < 13; x++) begin
            for (int y = 0; y < 13; y++) begin
                run_op(x, y, 13, mont_ref(x, y, 13), 1'b0, LAT, 0);
            end
        end

        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
